// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer.
// A Moore FSM steps one instruction through fetch, decode, execute, memory
// and write-back phases. It reuses one ALU and one unified memory port.
// Handshake: in FETCH, MEMRD and MEMWR the memory strobe and the address
// select are held steady until mem_ready is sampled high at a rising edge.
// That edge completes the access, and the FSM leaves the state on it.
// mem_ready has no effect in any other state.
// Outputs that depend only on the state come from registers loaded with the
// decode of the next state. pc_we, IRWrite and illegal are combined with live
// inputs in the same cycle.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] state,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       pc_we,
  output logic       PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [5:0] ALUCtrl,
  output logic       reg_res,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_SUB  = 6'b100010;

  // Control outputs that depend only on the state.
  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [5:0] alu_ctrl;
    logic       reg_res;
    logic       mem_to_reg;
    logic       reg_write;
  } moore_t;

  state_t state_q, state_d;
  moore_t out_q;

  // Moore output table. Any field a state does not set stays 0.
  function automatic moore_t moore_decode(input state_t s, input logic [5:0] fn);
    moore_t m;
    m = '0;
    case (s)
      S_FETCH: begin
        m.mem_read  = 1'b1;
        m.alu_src_b = 2'b01;
        m.alu_ctrl  = ALU_ADD;
      end
      S_DECODE: begin
        m.alu_src_b = 2'b11;
        m.alu_ctrl  = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        m.alu_src_a = 1'b1;
        m.alu_src_b = 2'b10;
        m.alu_ctrl  = ALU_ADD;
      end
      S_MEMRD: begin
        m.iord     = 1'b1;
        m.mem_read = 1'b1;
      end
      S_MEMWB: begin
        m.mem_to_reg = 1'b1;
        m.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        m.iord      = 1'b1;
        m.mem_write = 1'b1;
      end
      S_EXEC: begin
        m.alu_src_a = 1'b1;
        m.alu_ctrl  = fn;
      end
      S_RWB: begin
        m.reg_res   = 1'b1;
        m.reg_write = 1'b1;
      end
      S_BRANCH: begin
        m.alu_src_a = 1'b1;
        m.alu_ctrl  = ALU_SUB;
        m.pc_src    = 1'b1;
      end
      S_ADDIWB: begin
        m.reg_write = 1'b1;
      end
      default: m = '0;
    endcase
    return m;
  endfunction

  // Next-state selection: advance through the phases and stall on memory waits.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:       state_d = S_ADDIEX;
          default:       state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // State register plus registered Moore outputs. Reset loads the FETCH values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      out_q   <= moore_decode(S_FETCH, funct);
    end else begin
      state_q <= state_d;
      out_q   <= moore_decode(state_d, funct);
    end
  end

  logic op_legal;
  logic branch_taken;

  // Recognize supported opcodes and resolve the branch condition.
  always_comb begin
    op_legal = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
               (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_ADDI);
    branch_taken = 1'b0;
    if (opcode == OP_BEQ) branch_taken = zero;
    else if (opcode == OP_BNE) branch_taken = ~zero;
  end

  assign state    = state_q;
  assign IorD     = out_q.iord;
  assign MemRead  = out_q.mem_read;
  assign MemWrite = out_q.mem_write;
  assign PCSrc    = out_q.pc_src;
  assign ALUSrcA  = out_q.alu_src_a;
  assign ALUSrcB  = out_q.alu_src_b;
  assign ALUCtrl  = out_q.alu_ctrl;
  assign reg_res  = out_q.reg_res;
  assign MemToReg = out_q.mem_to_reg;
  assign RegWrite = out_q.reg_write;

  // The fetch completes in the cycle mem_ready arrives, so the IR load and
  // PC+4 follow it directly. Reset suppresses both.
  assign IRWrite = (state_q == S_FETCH) && mem_ready && !rst;
  assign pc_we   = !rst && (((state_q == S_FETCH) && mem_ready) ||
                            ((state_q == S_BRANCH) && branch_taken));
  assign illegal = (state_q == S_DECODE) && !op_legal;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl. It builds each instruction's expected
// phase sequence from the instruction class and the memory wait counts, then
// compares the state and all control outputs every cycle against a table of
// the documented per-phase control values.
module tb_mips_multicycle_ctrl;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic [3:0] state;
  logic       IorD, MemRead, MemWrite, IRWrite, pc_we, PCSrc, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [5:0] ALUCtrl;
  logic       reg_res, MemToReg, RegWrite, illegal;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .state(state), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .pc_we(pc_we), .PCSrc(PCSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUCtrl(ALUCtrl), .reg_res(reg_res),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .illegal(illegal)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    int st;
    bit rdy;
    bit z;
  } step_t;

  step_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  localparam int F = 0, D = 1, MA = 2, MR = 3, MW = 4, MWR = 5;
  localparam int EX = 6, RW = 7, BR = 8, AE = 9, AW = 10;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pack the DUT outputs as {IorD,MemRead,MemWrite,IRWrite,pc_we,PCSrc,ALUSrcA,
  // ALUSrcB,ALUCtrl,reg_res,MemToReg,RegWrite,illegal}.
  function automatic logic [18:0] dut_outs();
    return {IorD, MemRead, MemWrite, IRWrite, pc_we, PCSrc, ALUSrcA,
            ALUSrcB, ALUCtrl, reg_res, MemToReg, RegWrite, illegal};
  endfunction

  // Reference control values of a phase, taken from the documented phase table.
  function automatic logic [18:0] ref_outs(input int st, input bit mr, input bit z,
                                           input bit r, input logic [5:0] op,
                                           input logic [5:0] fn);
    logic iord, mrd, mwr, irw, pcw, pcs, asa, rr, m2r, rw, ill;
    logic [1:0] asb;
    logic [5:0] ac;
    bit legal;
    {iord, mrd, mwr, irw, pcw, pcs, asa, rr, m2r, rw, ill} = '0;
    asb = 2'b00;
    ac = 6'b000000;
    legal = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
            (op == 6'b000100) || (op == 6'b000101) || (op == 6'b001000);
    if (st == F)   begin mrd = 1; asb = 2'b01; ac = 6'b100000; irw = mr; pcw = mr; end
    if (st == D)   begin asb = 2'b11; ac = 6'b100000; ill = !legal; end
    if (st == MA || st == AE) begin asa = 1; asb = 2'b10; ac = 6'b100000; end
    if (st == MR)  begin iord = 1; mrd = 1; end
    if (st == MW)  begin m2r = 1; rw = 1; end
    if (st == MWR) begin iord = 1; mwr = 1; end
    if (st == EX)  begin asa = 1; ac = fn; end
    if (st == RW)  begin rr = 1; rw = 1; end
    if (st == BR)  begin
      asa = 1; ac = 6'b100010; pcs = 1;
      pcw = (op == 6'b000100) ? z : !z;
    end
    if (st == AW)  rw = 1;
    if (r) begin irw = 0; pcw = 0; end
    return {iord, mrd, mwr, irw, pcw, pcs, asa, asb, ac, rr, m2r, rw, ill};
  endfunction

  // ---------------- driver tasks ----------------
  // Queue one phase. Memory phases wait 'waits' cycles before ready. In the
  // other phases mem_ready is random because it must be ignored there.
  task automatic push_phase(input int st, input int waits, input bit z);
    step_t s;
    bit mem_phase;
    mem_phase = (st == F) || (st == MR) || (st == MWR);
    for (int i = 0; i < waits; i++) begin
      s.st = st; s.rdy = 1'b0; s.z = 1'($urandom_range(0, 1));
      exp_q.push_back(s);
    end
    s.st = st;
    s.rdy = mem_phase ? 1'b1 : 1'($urandom_range(0, 1));
    s.z = z;
    exp_q.push_back(s);
  endtask

  // Build the expected phase sequence for one instruction.
  task automatic queue_instr(input logic [5:0] op, input int wf, input int wm, input bit z);
    push_phase(F, wf, 1'($urandom_range(0, 1)));
    push_phase(D, 0, 1'($urandom_range(0, 1)));
    case (op)
      6'b000000: begin push_phase(EX, 0, 0); push_phase(RW, 0, 0); end
      6'b100011: begin push_phase(MA, 0, 0); push_phase(MR, wm, 0); push_phase(MW, 0, 0); end
      6'b101011: begin push_phase(MA, 0, 0); push_phase(MWR, wm, 0); end
      6'b000100, 6'b000101: push_phase(BR, 0, z);
      6'b001000: begin push_phase(AE, 0, 0); push_phase(AW, 0, 0); end
      default: ;
    endcase
  endtask

  // Drive each queued cycle after the edge, then check at the falling edge.
  task automatic run_queue(input string tag);
    step_t s;
    logic [18:0] got;
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      mem_ready = s.rdy;
      zero = s.z;
      @(negedge clk);
      check({tag, ".state"}, 32'(state), 32'(s.st));
      got = dut_outs();
      check({tag, ".outs"}, 32'(got), 32'(ref_outs(s.st, s.rdy, s.z, rst, opcode, funct)));
      check({tag, ".excl"}, 32'((MemRead & MemWrite) | (RegWrite & MemWrite)), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                          input int wf, input int wm, input bit z);
    opcode = op;
    funct = fn;
    queue_instr(op, wf, wm, z);
    run_queue(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] ops[7];
    logic [5:0] op;
    step_t s;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000, 6'b111111};

    // Hold reset for two cycles with mem_ready high.
    rst = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("reset.state", 32'(state), 32'd0);
      check("reset.outs", 32'(dut_outs()), 32'(ref_outs(F, 1'b1, zero, 1'b1, opcode, funct)));
      check("reset.irw_pcwe", 32'({IRWrite, pc_we}), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed cases.
    do_instr("radd", 6'b000000, 6'b100000, 0, 0, 0);
    do_instr("lw_wait3", 6'b100011, 6'h15, 0, 3, 0);
    do_instr("beq_z1", 6'b000100, 6'h00, 0, 0, 1);
    do_instr("beq_z0", 6'b000100, 6'h00, 0, 0, 0);
    do_instr("bne_z0", 6'b000101, 6'h00, 0, 0, 0);
    do_instr("illegal", 6'b111111, 6'h00, 0, 0, 0);
    do_instr("sw", 6'b101011, 6'h00, 1, 2, 0);

    // Reset arrives while sw waits in MEMWR.
    opcode = 6'b101011;
    push_phase(F, 0, 0);
    push_phase(D, 0, 0);
    push_phase(MA, 0, 0);
    s.st = MWR; s.rdy = 1'b0; s.z = 1'b0;
    exp_q.push_back(s);
    exp_q.push_back(s);
    run_queue("sw_pre_rst");
    rst = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    check("sw_rst.hold_state", 32'(state), 32'(MWR));
    check("sw_rst.hold_outs", 32'(dut_outs()), 32'(ref_outs(MWR, 1'b0, zero, 1'b1, opcode, funct)));
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    @(negedge clk);
    check("sw_rst.state", 32'(state), 32'd0);
    check("sw_rst.outs", 32'(dut_outs()), 32'(ref_outs(F, 1'b1, zero, 1'b1, opcode, funct)));
    check("sw_rst.memwrite", 32'(MemWrite), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Random instruction stream with random memory waits.
    for (int i = 0; i < 200; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      do_instr("rand", op, 6'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom_range(0, 1)));
    end

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
